// File: rtl/ws2812b_pkg.sv
// Shared FSM encoding and default WS2812B timing (clk cycles at 12 MHz).
package ws2812b_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_LATCH = 2'd3
  } ws_state_e;

  localparam int DEF_T0H_CYCLES   = 4;
  localparam int DEF_T1H_CYCLES   = 8;
  localparam int DEF_BIT_CYCLES   = 15;
  localparam int DEF_LATCH_CYCLES = 600;
  localparam int PIXEL_W          = 24;
endpackage

// File: rtl/ws2812b_bit_timer.sv
// Bit-period counter: high-phase strobe for the current bit and a last-cycle strobe.
module ws2812b_bit_timer
  import ws2812b_pkg::*;
#(
  parameter int T0H_CYCLES = DEF_T0H_CYCLES,
  parameter int T1H_CYCLES = DEF_T1H_CYCLES,
  parameter int BIT_CYCLES = DEF_BIT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_bit,
  output logic o_hi,
  output logic o_last
);
  localparam int CW = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] T0H     = CW'(T0H_CYCLES);
  localparam logic [CW-1:0] T1H     = CW'(T1H_CYCLES);

  logic [CW-1:0] r_cnt;

  // Held at zero while disabled so every enable starts on a bit boundary.
  always_ff @(posedge clk) begin
    if (rst || !i_en || o_last) r_cnt <= '0;
    else                        r_cnt <= r_cnt + 1'b1;
  end

  assign o_last = i_en && (r_cnt == CNT_MAX);
  assign o_hi   = r_cnt < (i_bit ? T1H : T0H);
endmodule

// File: rtl/ws2812b_serializer.sv
// WS2812B pixel serializer: one-deep holding buffer, 24-bit shifter, GAP/LATCH framing.
module ws2812b_serializer
  import ws2812b_pkg::*;
#(
  parameter int T0H_CYCLES   = DEF_T0H_CYCLES,
  parameter int T1H_CYCLES   = DEF_T1H_CYCLES,
  parameter int BIT_CYCLES   = DEF_BIT_CYCLES,
  parameter int LATCH_CYCLES = DEF_LATCH_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PIXEL_W-1:0] i_pixel,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic               i_latch,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_led
);
  localparam int LW = $clog2(LATCH_CYCLES);
  localparam int IW = $clog2(PIXEL_W);
  localparam logic [LW-1:0] LAT_MAX = LW'(LATCH_CYCLES - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(PIXEL_W - 1);

  ws_state_e          r_state, w_state_nxt;
  logic [PIXEL_W-1:0] r_buf, r_shift;
  logic               r_buf_full, r_pend;
  logic [IW-1:0]      r_idx;
  logic [LW-1:0]      r_lcnt;
  logic               r_led, r_done_pre, r_done;
  logic               w_ready, w_busy, w_bit_en, w_led_nxt;
  logic               w_hi, w_last, w_acc, w_word_end, w_load, w_lat_last, w_latch_take;

  ws2812b_bit_timer #(
    .T0H_CYCLES(T0H_CYCLES),
    .T1H_CYCLES(T1H_CYCLES),
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_bit_en),
    .i_bit (r_shift[PIXEL_W-1]),
    .o_hi  (w_hi),
    .o_last(w_last)
  );

  assign w_acc        = i_valid && w_ready;
  assign w_word_end   = (r_state == ST_SHIFT) && w_last && (r_idx == IDX_MAX);
  assign w_load       = r_buf_full && ((r_state == ST_IDLE) || w_word_end ||
                                       ((r_state == ST_GAP) && w_last));
  assign w_lat_last   = (r_state == ST_LATCH) && (r_lcnt == LAT_MAX);
  // A latch with nothing sent or accepted in this frame is dropped.
  assign w_latch_take = i_latch && !((r_state == ST_IDLE) && !r_buf_full && !w_acc);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (r_buf_full) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_word_end && !r_buf_full) w_state_nxt = r_pend ? ST_LATCH : ST_GAP;
      ST_GAP: begin
        if (w_last) begin
          if (r_buf_full)  w_state_nxt = ST_SHIFT;
          else if (r_pend) w_state_nxt = ST_LATCH;
        end
      end
      ST_LATCH: if (w_lat_last) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_ready   = !r_buf_full && !r_pend && (r_state != ST_LATCH);
    w_busy    = (r_state != ST_IDLE);
    w_bit_en  = (r_state == ST_SHIFT) || (r_state == ST_GAP);
    w_led_nxt = (r_state == ST_SHIFT) && w_hi;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      r_shift    <= '0;
      r_idx      <= '0;
      r_pend     <= 1'b0;
      r_lcnt     <= '0;
      r_led      <= 1'b0;
      r_done_pre <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      if (w_load) begin
        r_buf_full <= 1'b0;
      end else if (w_acc) begin
        r_buf_full <= 1'b1;
        r_buf      <= i_pixel;
      end
      if (w_load) begin
        r_shift <= r_buf;
        r_idx   <= '0;
      end else if ((r_state == ST_SHIFT) && w_last) begin
        r_shift <= {r_shift[PIXEL_W-2:0], 1'b0};
        r_idx   <= w_word_end ? '0 : r_idx + 1'b1;
      end
      if (w_lat_last)        r_pend <= 1'b0;
      else if (w_latch_take) r_pend <= 1'b1;
      r_lcnt <= ((r_state == ST_LATCH) && !w_lat_last) ? r_lcnt + 1'b1 : '0;
      // o_led trails the state by one cycle; o_done is delayed twice so it
      // lands on the cycle after the final latch-low cycle seen on the line.
      r_led      <= w_led_nxt;
      r_done_pre <= w_lat_last;
      r_done     <= r_done_pre;
    end
  end

  assign o_ready = w_ready;
  assign o_busy  = w_busy;
  assign o_led   = r_led;
  assign o_done  = r_done;
endmodule

// File: tb/tb_ws2812b_serializer.sv
// Scoreboard bench: the driver queues expected bits/latches, a monitor decodes o_led.
module tb_ws2812b_serializer;
  localparam int T0H = 4, T1H = 8, BITC = 15, LATC = 600;

  logic        clk = 1'b0, rst = 1'b1;
  logic [23:0] i_pixel = '0;
  logic        i_valid = 1'b0, i_latch = 1'b0;
  logic        o_ready, o_busy, o_done, o_led;

  ws2812b_serializer #(
    .T0H_CYCLES(T0H), .T1H_CYCLES(T1H), .BIT_CYCLES(BITC), .LATCH_CYCLES(LATC)
  ) dut (
    .clk(clk), .rst(rst), .i_pixel(i_pixel), .i_valid(i_valid), .o_ready(o_ready),
    .i_latch(i_latch), .o_busy(o_busy), .o_done(o_done), .o_led(o_led)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  int exp_q[$];          // 0/1 = expected bit, 2 = expected latch
  bit frame_has = 1'b0;  // pixels accepted since the last latch
  int n_bits = 0, n_gaps = 0, n_done = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: decode pulses into bits and compare against the queue.
  initial begin
    bit m_prev = 0, m_have = 0;
    int m_hcnt = 0, m_lcnt = 0, m_pos = 0, m_last_rise = 0, m_th = 0, per, b;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        m_prev = 0; m_have = 0; m_hcnt = 0; m_lcnt = 0; m_pos = 0;
      end else begin
        if (o_done) begin
          n_done++;
          if (exp_q.size() == 0 || exp_q[0] != 2) chk("unexpected_done", 1, 0);
          else begin
            void'(exp_q.pop_front());
            chk("latch_low_cycles", m_lcnt, BITC - m_th + LATC);
            chk("led_low_at_done", o_led, 0);
          end
          m_have = 0; m_pos = 0;
        end
        if (o_led && !m_prev) begin
          if (m_have) begin
            per = cyc - m_last_rise;
            if (m_pos % 24 != 0) chk("bit_period", per, BITC);
            else begin
              chk("pixel_boundary_align", per % BITC, 0);
              if (per > BITC) n_gaps++;
            end
          end
          m_have = 1; m_last_rise = cyc; m_hcnt = 0;
        end
        if (!o_led && m_prev) begin
          if (exp_q.size() == 0 || exp_q[0] == 2) chk("unexpected_pulse", m_hcnt, 0);
          else begin
            b = exp_q.pop_front();
            chk("high_width", m_hcnt, (b != 0) ? T1H : T0H);
          end
          m_th = m_hcnt; m_pos++; n_bits++; m_lcnt = 0;
        end
        if (o_led) m_hcnt++;
        else       m_lcnt++;
        m_prev = o_led;
      end
    end
  end

  task automatic send(input logic [23:0] p, input bit lat);
    int guard = 0;
    bit fin = 0;
    while (!fin) begin
      @(negedge clk);
      i_pixel = p; i_valid = 1'b1;
      if (o_ready) begin
        i_latch = lat; fin = 1;
        for (int k = 23; k >= 0; k--) exp_q.push_back(int'(p[k]));
        frame_has = 1'b1;
        if (lat) begin exp_q.push_back(2); frame_has = 1'b0; end
      end else begin
        i_latch = 1'b0; guard++;
        if (guard > 3000) begin chk("ready_timeout", 0, 1); fin = 1; end
      end
    end
    @(negedge clk);
    i_valid = 1'b0; i_latch = 1'b0;
  endtask

  task automatic req_latch();
    @(negedge clk);
    i_latch = 1'b1;
    if (frame_has) begin exp_q.push_back(2); frame_has = 1'b0; end
    @(negedge clk);
    i_latch = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int guard = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || o_busy) && guard < 20000) begin
      @(negedge clk); guard++;
    end
    chk(name, guard < 20000, 1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int b0, g0, d0, bad, guard, np;
    bit lat;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_led", o_led, 0);
    chk("reset_ready", o_ready, 1);
    chk("reset_busy", o_busy, 0);
    chk("reset_done", o_done, 0);
    rst = 1'b0;

    // Single pixel 800000 with latch; first rise two cycles after acceptance
    d0 = n_done; b0 = n_bits;
    send(24'h800000, 1'b0);
    chk("latency_c0", o_led, 0);
    @(negedge clk); chk("latency_c1", o_led, 0);
    @(negedge clk); chk("latency_c2", o_led, 1);
    req_latch();
    wait_idle("s1_idle");
    chk("s1_bits", n_bits - b0, 24);
    chk("s1_done", n_done - d0, 1);

    // Back-to-back FFFFFF / 000000: no gap between pixels
    g0 = n_gaps; b0 = n_bits;
    send(24'hFFFFFF, 1'b0);
    send(24'h000000, 1'b1);
    wait_idle("s2_idle");
    chk("s2_bits", n_bits - b0, 48);
    chk("s2_no_gap", n_gaps - g0, 0);

    // Valid held through not-ready: three pixels, no duplicates
    b0 = n_bits;
    for (int i = 0; i < 3; i++) send(24'($urandom), i == 2);
    wait_idle("s3_idle");
    chk("s3_bits", n_bits - b0, 72);

    // Underrun: 40 idle cycles after first pixel, second on a bit boundary
    g0 = n_gaps; b0 = n_bits;
    send(24'($urandom), 1'b0);
    guard = 0;
    while (n_bits < b0 + 24 && guard < 2000) begin @(negedge clk); guard++; end
    chk("s4_first_pixel", n_bits - b0, 24);
    bad = 0;
    repeat (40) begin @(negedge clk); if (o_led !== 1'b0) bad++; end
    chk("s4_gap_low", bad, 0);
    send(24'($urandom), 1'b1);
    wait_idle("s4_idle");
    chk("s4_one_gap", n_gaps - g0, 1);
    chk("s4_bits", n_bits - b0, 48);

    // Reset at bit 10 of a pixel
    b0 = n_bits;
    send(24'hA5C3F0, 1'b0);
    guard = 0;
    while (n_bits < b0 + 10 && guard < 2000) begin @(negedge clk); guard++; end
    rst = 1'b1;
    exp_q.delete(); frame_has = 1'b0;
    @(negedge clk);
    chk("s5_led_after_rst", o_led, 0);
    chk("s5_ready_after_rst", o_ready, 1);
    chk("s5_busy_after_rst", o_busy, 0);
    rst = 1'b0;
    d0 = n_done; b0 = n_bits; bad = 0;
    repeat (700) begin @(negedge clk); if (o_done || o_led) bad++; end
    chk("s5_quiet", bad, 0);
    chk("s5_no_done", n_done - d0, 0);
    chk("s5_no_bits", n_bits - b0, 0);

    // Latch in IDLE with no data is ignored
    req_latch();
    bad = 0;
    repeat (50) begin @(negedge clk); if (o_busy || o_done || o_led) bad++; end
    chk("s6_idle_latch_ignored", bad, 0);

    // Random frames: 1-3 pixels, random spacing, latch with or after the last pixel
    for (int f = 0; f < 5; f++) begin
      b0 = n_bits; d0 = n_done;
      np = int'($urandom_range(1, 3));
      lat = 1'($urandom);
      for (int i = 0; i < np; i++) begin
        repeat ($urandom_range(0, 60)) @(negedge clk);
        send(24'($urandom), (i == np - 1) && lat);
      end
      if (!lat) req_latch();
      wait_idle("rnd_idle");
      chk("rnd_bits", n_bits - b0, 24 * np);
      chk("rnd_done", n_done - d0, 1);
    end

    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ws2812b_serializer.md
WS2812B_SERIALIZER -- requirements
Module: ws2812b_serializer

Interface
REQ-001 SHALL have parameter T0H_CYCLES, default 4, giving the high time of a 0 bit in clk cycles (0.33 us at 12 MHz).
REQ-002 SHALL have parameter T1H_CYCLES, default 8, giving the high time of a 1 bit in clk cycles.
REQ-003 SHALL have parameter BIT_CYCLES, default 15, giving the total bit period in clk cycles (1.25 us).
REQ-004 SHALL have parameter LATCH_CYCLES, default 600, giving the minimum low time in clk cycles for a frame latch (50 us).
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port i_pixel, input, 24 bits: the pixel in GRB order, with bit 23 sent first.
REQ-008 SHALL have port i_valid, input, 1 bit: i_pixel holds a valid pixel.
REQ-009 SHALL have port o_ready, output, 1 bit: the holding buffer can accept a pixel.
REQ-010 SHALL have port i_latch, input, 1 bit: a one-cycle request to end the frame.
REQ-011 SHALL have port o_busy, output, 1 bit: high whenever the block is not in IDLE.
REQ-012 SHALL have port o_done, output, 1 bit: a one-cycle pulse when the latch completes.
REQ-013 SHALL have port o_led, output, 1 bit: the serial line to the matrix DIN.

Function
REQ-014 SHALL accept a pixel into a 24-bit holding buffer on any cycle where i_valid and o_ready are both high.
REQ-015 SHALL drive o_ready = holding buffer empty AND no latch pending AND state is not LATCH.
REQ-016 SHALL use an FSM with states IDLE, SHIFT, GAP and LATCH.
REQ-017 SHALL move IDLE->SHIFT on the cycle after the buffer fills, loading the buffer into the shifter and emptying the buffer.
REQ-018 SHALL, in SHIFT, drive o_led high for bit-cycle counts 0..T(h)-1 and low for T(h)..BIT_CYCLES-1, where T(h) is T1H_CYCLES when the current bit is 1 and T0H_CYCLES when it is 0.
REQ-019 SHALL, at the last cycle of the last bit, reload the shifter from a full buffer so the next pixel's bit 23 starts on the very next cycle with no gap.
REQ-020 SHALL, at the last cycle of the last bit with the buffer empty: go to LATCH if a latch is pending, otherwise go to GAP.
REQ-021 SHALL, in GAP, hold o_led low and leave GAP at a bit boundary as soon as the buffer fills (to SHIFT) or a latch is pending (to LATCH).
REQ-022 SHALL register i_latch as a pending flag, and SHALL ignore i_latch in IDLE while the buffer is empty, producing no frame.
REQ-023 SHALL, in LATCH, hold o_led low for exactly LATCH_CYCLES cycles, then pulse o_done for one cycle, clear the pending flag and return to IDLE.
REQ-024 SHALL give simultaneous i_valid (accepted) and i_latch the meaning: the accepted pixel is sent before the latch.
REQ-025 SHALL size counters with $clog2 of their parameter, and SHALL NOT let any counter exceed its parameter minus 1.
REQ-026 SHALL register o_led directly from a flop, with no combinational path from inputs.
REQ-027 SHALL have a latency of 2 cycles from acceptance in IDLE to the first rising edge of o_led.

Reset
REQ-028 SHALL, while rst is high at a clk edge: set state IDLE, o_led=0, o_done=0, o_busy=0, o_ready=1, buffer empty, latch pending cleared, and all counters 0.
REQ-029 SHALL, on reset during SHIFT or LATCH, abort immediately and drive o_led low from the next cycle; any partially sent pixel is discarded.

Structure
REQ-030 SHALL place the FSM state enum and default timing constants in a shared package ws2812b_pkg, which the output controller also imports.
REQ-031 SHALL contain one natural sub-module, ws2812b_bit_timer: a bit-cycle counter producing high-phase and last-cycle strobes.
REQ-032 SHALL be implementable in 120-400 lines of RTL in total.

Verification
REQ-033 SHALL verify: pixel 24'h800000 then i_latch -> o_led high 8 cycles, low 7 cycles; then 23 bits of high 4 / low 11; then 600 low cycles; then o_done pulses once.
REQ-034 SHALL verify: two pixels 24'hFFFFFF and 24'h000000, with the second offered while the first is shifting -> 48 contiguous bit periods with no extra low cycles between pixels.
REQ-035 SHALL verify: i_valid held high with o_ready low -> no pixel accepted and no duplicates, counting 3 pixels offered = 72 bit periods observed.
REQ-036 SHALL verify: underrun with a 40-cycle delay before the second pixel -> o_led low during GAP, and the second pixel starts on a bit boundary (cycle offset is a multiple of 15).
REQ-037 SHALL verify: rst asserted at bit 10 of a pixel -> o_led=0 and o_ready=1 on the next cycle, and no o_done.
REQ-038 SHALL verify: i_latch in IDLE with no data -> o_busy stays 0, o_done stays 0 and o_led stays 0.
